// File: rtl/epmp_pkg.sv
// rtl/epmp_pkg.sv - shared types and constants for the EPMP memory address register
package epmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/epmp_mar_seq_if.sv
// rtl/epmp_mar_seq_if.sv - memory-side address handshake channel
interface epmp_mar_seq_if #(
    parameter int AW = 16
);
    logic [AW-1:0] a;
    logic          a_valid;
    logic          a_ready;

    modport master (output a, output a_valid, input a_ready);
    modport slave  (input a, input a_valid, output a_ready);
endinterface

// File: rtl/epmp_addr_step.sv
// rtl/epmp_addr_step.sv - one-step up/down address increment with optional page wrap
module epmp_addr_step
    import epmp_pkg::*;
#(
    parameter int AW        = 16,
    parameter int PAGE_BITS = 8
) (
    input  logic [AW-1:0] i_a,
    input  logic          i_dir,
    input  logic          i_page_wrap,
    output logic [AW-1:0] o_next,
    output logic          o_wrap
);

    // Mask of the low field that counts in page mode; built one bit wider so PAGE_BITS == AW is legal.
    localparam logic [AW:0]   PAGE_MASK_W = ({{AW{1'b0}}, 1'b1} << PAGE_BITS) - {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PAGE_MASK   = PAGE_MASK_W[AW-1:0];

    logic [AW-1:0] w_full_next;
    logic [AW-1:0] w_mask;

    always_comb begin
        w_mask      = i_page_wrap ? PAGE_MASK : {AW{1'b1}};
        w_full_next = (i_dir == DIR_DOWN) ? (i_a - {{(AW-1){1'b0}}, 1'b1})
                                          : (i_a + {{(AW-1){1'b0}}, 1'b1});
        o_next      = (i_a & ~w_mask) | (w_full_next & w_mask);
        if (i_dir == DIR_DOWN) begin
            o_wrap = ((i_a & w_mask) == {AW{1'b0}});
        end else begin
            o_wrap = ((i_a & w_mask) == w_mask);
        end
    end

endmodule

// File: rtl/epmp_mar_seq.sv
// rtl/epmp_mar_seq.sv - byte-loadable address register with single-step and burst sequencing
module epmp_mar_seq
    import epmp_pkg::*;
#(
    parameter int AW        = 16,
    parameter int CW        = 8,
    parameter int PAGE_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   i_ib,
    input  logic [AW/8-1:0] i_be,
    input  logic            i_ld,
    input  logic            i_inc,
    input  logic            i_dec,
    input  logic            i_page_wrap,
    input  logic            i_burst_start,
    input  logic [CW-1:0]   i_burst_len,
    input  logic            i_burst_dir,
    input  logic            i_burst_abort,
    epmp_mar_seq_if.master  mem,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_carry
);

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_a;
    logic [CW-1:0] r_rem;
    logic          r_dir;
    logic          r_carry;

    logic          w_idle;
    logic          w_hs;
    logic          w_abort;
    logic          w_step_en;
    logic          w_step_dir;
    logic [AW-1:0] w_step_next;
    logic          w_step_wrap;
    logic [AW-1:0] w_ld_val;

    assign w_idle  = (r_state == IDLE);
    assign w_abort = i_burst_abort && !w_idle;
    assign w_hs    = (r_state == BURST) && mem.a_ready;

    // In IDLE the step comes from inc/dec (both together cancel); in BURST only an accepted address steps.
    assign w_step_en  = w_idle ? (!i_ld && (i_inc ^ i_dec)) : (w_hs && !w_abort);
    assign w_step_dir = w_idle ? (i_dec ? DIR_DOWN : DIR_UP) : r_dir;

    epmp_addr_step #(
        .AW        (AW),
        .PAGE_BITS (PAGE_BITS)
    ) u_step (
        .i_a         (r_a),
        .i_dir       (w_step_dir),
        .i_page_wrap (i_page_wrap),
        .o_next      (w_step_next),
        .o_wrap      (w_step_wrap)
    );

    always_comb begin
        w_ld_val = r_a;
        for (int k = 0; k < AW/8; k++) begin
            if (i_be[k]) begin
                w_ld_val[8*k +: 8] = i_ib[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_burst_start) begin
                    w_next_state = (i_burst_len == '0) ? DONE : BURST;
                end
            end
            BURST: begin
                if (i_burst_abort) begin
                    w_next_state = IDLE;
                end else if (w_hs && (r_rem == CW'(1))) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        mem.a       = r_a;
        mem.a_valid = (r_state == BURST);
        o_busy      = (r_state != IDLE);
        o_done      = (r_state == DONE);
        o_carry     = r_carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_rem   <= '0;
            r_dir   <= DIR_UP;
            r_carry <= 1'b0;
        end else begin
            r_carry <= w_step_en && w_step_wrap;
            if (w_idle && i_ld) begin
                r_a <= w_ld_val;
            end else if (w_step_en) begin
                r_a <= w_step_next;
            end
            if (w_idle && i_burst_start) begin
                r_rem <= i_burst_len;
                r_dir <= i_burst_dir;
            end else if (w_abort) begin
                r_rem <= '0;
            end else if (w_hs) begin
                r_rem <= r_rem - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_epmp_mar_seq.sv
// tb/tb_epmp_mar_seq.sv - directed self-checking bench for epmp_mar_seq
module tb_epmp_mar_seq;
    import epmp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ib;
    logic [1:0]  be;
    logic        ld, inc, dec, page_wrap, burst_start, burst_dir, burst_abort;
    logic [7:0]  burst_len;
    logic        busy, done, carry;
    int          n_cmp = 0;
    int          n_fail = 0;

    epmp_mar_seq_if #(.AW(16)) mem_if ();

    epmp_mar_seq #(.AW(16), .CW(8), .PAGE_BITS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ib          (ib),
        .i_be          (be),
        .i_ld          (ld),
        .i_inc         (inc),
        .i_dec         (dec),
        .i_page_wrap   (page_wrap),
        .i_burst_start (burst_start),
        .i_burst_len   (burst_len),
        .i_burst_dir   (burst_dir),
        .i_burst_abort (burst_abort),
        .mem           (mem_if.master),
        .o_busy        (busy),
        .o_done        (done),
        .o_carry       (carry)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        ld = 1'b1; be = 2'b11; ib = v;
        tick();
        ld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ib = '0; be = '0; ld = 0; inc = 0; dec = 0; page_wrap = 0;
        burst_start = 0; burst_len = '0; burst_dir = 0; burst_abort = 0; mem_if.a_ready = 0;
        tick(); tick();
        n_cmp++; if (mem_if.a !== 16'h0000) begin n_fail++; $display("FAIL reset_a got %h want 0000", mem_if.a); end
        n_cmp++; if ({mem_if.a_valid, busy, done, carry} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {mem_if.a_valid, busy, done, carry}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        load(16'h1234);
        n_cmp++; if (mem_if.a !== 16'h1234) begin n_fail++; $display("FAIL load_full got %h want 1234", mem_if.a); end
        ld = 1'b1; be = 2'b01; ib = 16'hFFAB;
        tick();
        ld = 1'b0;
        n_cmp++; if (mem_if.a !== 16'h12AB) begin n_fail++; $display("FAIL load_lane0 got %h want 12AB", mem_if.a); end
        ld = 1'b1; be = 2'b10; ib = 16'h5600;
        tick();
        ld = 1'b0;
        n_cmp++; if (mem_if.a !== 16'h56AB) begin n_fail++; $display("FAIL load_lane1 got %h want 56AB", mem_if.a); end
    endtask

    task automatic test_step();
        load(16'h12FF);
        page_wrap = 1'b1; inc = 1'b1;
        tick();
        inc = 1'b0;
        n_cmp++; if (mem_if.a !== 16'h1200) begin n_fail++; $display("FAIL page_inc got %h want 1200", mem_if.a); end
        n_cmp++; if (carry !== 1'b1) begin n_fail++; $display("FAIL page_carry got %b want 1", carry); end
        tick();
        n_cmp++; if (carry !== 1'b0) begin n_fail++; $display("FAIL carry_pulse got %b want 0", carry); end
        load(16'h12FF);
        page_wrap = 1'b0; inc = 1'b1;
        tick();
        inc = 1'b0;
        n_cmp++; if (mem_if.a !== 16'h1300) begin n_fail++; $display("FAIL full_inc got %h want 1300", mem_if.a); end
        n_cmp++; if (carry !== 1'b0) begin n_fail++; $display("FAIL full_nocarry got %b want 0", carry); end
        page_wrap = 1'b1; dec = 1'b1;
        tick();
        dec = 1'b0;
        n_cmp++; if (mem_if.a !== 16'h13FF || carry !== 1'b1) begin n_fail++; $display("FAIL page_dec got %h/%b want 13FF/1", mem_if.a, carry); end
        inc = 1'b1; dec = 1'b1;
        tick();
        inc = 1'b0; dec = 1'b0; page_wrap = 1'b0;
        n_cmp++; if (mem_if.a !== 16'h13FF) begin n_fail++; $display("FAIL inc_dec_hold got %h want 13FF", mem_if.a); end
    endtask

    task automatic test_burst_up();
        load(16'h0100);
        mem_if.a_ready = 1'b1; burst_len = 8'd4; burst_dir = DIR_UP; burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem_if.a_valid !== 1'b1 || mem_if.a !== 16'h0100 + 16'(i) || done !== 1'b0) begin
                n_fail++; $display("FAIL burst_up_addr%0d got %h v=%b d=%b want %h v=1 d=0", i, mem_if.a, mem_if.a_valid, done, 16'h0100 + 16'(i)); end
            ld = (i == 1); ib = 16'h0000; be = 2'b11;
            tick();
        end
        ld = 1'b0;
        n_cmp++; if (done !== 1'b1 || mem_if.a_valid !== 1'b0 || mem_if.a !== 16'h0104) begin
            n_fail++; $display("FAIL burst_up_done got d=%b v=%b a=%h want d=1 v=0 a=0104", done, mem_if.a_valid, mem_if.a); end
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL burst_up_idle got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_ready_toggle();
        int acc = 0;
        int cyc = 0;
        load(16'h0100);
        burst_len = 8'd4; burst_dir = DIR_UP; burst_start = 1'b1; mem_if.a_ready = 1'b1;
        tick();
        burst_start = 1'b0;
        while (acc < 4 && cyc < 20) begin
            n_cmp++; if (mem_if.a_valid !== 1'b1 || done !== 1'b0 || mem_if.a !== 16'h0100 + 16'(acc)) begin
                n_fail++; $display("FAIL toggle_cyc%0d got a=%h v=%b d=%b want a=%h v=1 d=0", cyc, mem_if.a, mem_if.a_valid, done, 16'h0100 + 16'(acc)); end
            mem_if.a_ready = (cyc % 2 == 0);
            if (mem_if.a_ready) acc++;
            tick();
            cyc++;
        end
        mem_if.a_ready = 1'b1;
        n_cmp++; if (cyc !== 7) begin n_fail++; $display("FAIL toggle_cycles got %0d want 7", cyc); end
        n_cmp++; if (done !== 1'b1 || mem_if.a !== 16'h0104) begin n_fail++; $display("FAIL toggle_done got d=%b a=%h want 1 0104", done, mem_if.a); end
        tick();
    endtask

    task automatic test_zero_len();
        burst_len = 8'd0; burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        n_cmp++; if (done !== 1'b1 || mem_if.a_valid !== 1'b0 || mem_if.a !== 16'h0104) begin
            n_fail++; $display("FAIL zero_len got d=%b v=%b a=%h want 1 0 0104", done, mem_if.a_valid, mem_if.a); end
        tick();
        n_cmp++; if (busy !== 1'b0 || mem_if.a_valid !== 1'b0) begin n_fail++; $display("FAIL zero_len_idle got busy=%b v=%b want 0 0", busy, mem_if.a_valid); end
    endtask

    task automatic test_abort();
        load(16'h0200);
        mem_if.a_ready = 1'b1; burst_len = 8'd5; burst_dir = DIR_UP; burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        tick(); tick();
        burst_abort = 1'b1;
        tick();
        burst_abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || mem_if.a !== 16'h0202 || mem_if.a_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort got busy=%b d=%b v=%b a=%h want 0 0 0 0202", busy, done, mem_if.a_valid, mem_if.a); end
        tick();
        n_cmp++; if (done !== 1'b0 || mem_if.a !== 16'h0202) begin n_fail++; $display("FAIL abort_after got d=%b a=%h want 0 0202", done, mem_if.a); end
    endtask

    task automatic test_burst_down_wrap();
        load(16'h0000);
        page_wrap = 1'b0; mem_if.a_ready = 1'b1; burst_len = 8'd2; burst_dir = DIR_DOWN; burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        n_cmp++; if (mem_if.a !== 16'h0000 || mem_if.a_valid !== 1'b1 || carry !== 1'b0) begin
            n_fail++; $display("FAIL down_first got a=%h v=%b c=%b want 0000 1 0", mem_if.a, mem_if.a_valid, carry); end
        tick();
        n_cmp++; if (mem_if.a !== 16'hFFFF || mem_if.a_valid !== 1'b1 || carry !== 1'b1) begin
            n_fail++; $display("FAIL down_second got a=%h v=%b c=%b want FFFF 1 1", mem_if.a, mem_if.a_valid, carry); end
        tick();
        n_cmp++; if (mem_if.a !== 16'hFFFE || done !== 1'b1 || carry !== 1'b0) begin
            n_fail++; $display("FAIL down_done got a=%h d=%b c=%b want FFFE 1 0", mem_if.a, done, carry); end
        tick();
    endtask

    task automatic test_async_reset();
        load(16'h0300);
        mem_if.a_ready = 1'b1; burst_len = 8'd10; burst_dir = DIR_UP; burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_if.a !== 16'h0000 || {mem_if.a_valid, busy, done, carry} !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset got a=%h flags=%b want 0000 0000", mem_if.a, {mem_if.a_valid, busy, done, carry}); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_burst_up();
        test_ready_toggle();
        test_zero_len();
        test_abort();
        test_burst_down_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/epmp_mar_seq.md
# epmp_mar_seq

Parametrised memory address register for the EPMP datapath, successor to the fixed 16-bit load-only MAR. It loads the address from the internal bus per byte lane, steps it up or down with optional page wrap, and runs an autonomous burst that presents a sequence of addresses to the memory interface over a valid/ready handshake. It sits between the internal bus (IB) and the memory address pins.

## Interface
- AW, 16, address width in bits; multiple of 8, 8..32
- CW, 8, burst length counter width
- PAGE_BITS, 8, width of the low address field that wraps in page mode; 1..AW
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ib  in  AW  internal bus load data
- be  in  AW/8  byte-lane enables for ld; lane k covers ib[8k+7:8k]
- ld  in  1  load enabled lanes of ib into a
- inc  in  1  a <= a + 1 (single step)
- dec  in  1  a <= a - 1 (single step)
- page_wrap  in  1  1: only a[PAGE_BITS-1:0] counts and a[AW-1:PAGE_BITS] holds; 0: full AW wrap
- burst_start  in  1  begin burst of burst_len addresses from current a
- burst_len  in  CW  burst address count, sampled on burst_start
- burst_dir  in  1  0 up, 1 down; sampled on burst_start
- burst_abort  in  1  terminate burst immediately
- a_ready  in  1  memory side accepts presented address
- a  out  AW  address register
- a_valid  out  1  a is a burst address awaiting acceptance
- busy  out  1  burst in progress (state != IDLE)
- done  out  1  one-cycle pulse: burst completed normally
- carry  out  1  one-cycle pulse: last step wrapped its active field

## Operation
- Reset: a = 0, a_valid = 0, busy = 0, done = 0, carry = 0, state IDLE, remaining count 0.
- States: IDLE, BURST, DONE.
- IDLE priority: ld applies first (lanes with be=0 hold); if no ld, exactly one of inc/dec steps a; inc and dec together hold a.
- ld and burst_start in the same cycle: load applies, burst starts from the loaded value.
- IDLE and burst_start: burst_len = 0 -> DONE directly, no address presented; else capture length and direction -> BURST.
- BURST: a_valid = 1. On a_valid & a_ready, a steps in the captured direction and remaining decrements; if remaining was 1 -> DONE. a_ready low -> a and count hold. ld, inc, dec, burst_start ignored.
- DONE: lasts one cycle, done = 1, a_valid = 0 -> IDLE. a holds the value one step past the last accepted address.
- burst_abort in BURST or DONE -> IDLE next cycle, no done pulse, a holds. Ignored in IDLE. Takes priority over a simultaneous handshake; that handshake does not step a.
- Stepping: with page_wrap = 1, low field wraps mod 2^PAGE_BITS and upper bits are untouched. With page_wrap = 0, wrap is mod 2^AW. carry pulses on the cycle after a step from all-ones (up) or zero (down) of the active field.
- page_wrap is live every cycle and is not sampled.

## Timing
- ld/inc/dec: visible on a one cycle after the sampling edge.
- burst_start at edge N: a_valid high from N+1. With a_ready held high, one address per cycle; the L addresses occupy N+1..N+L, and done is high in cycle N+L+1.
- a, a_valid, busy, done, carry are all registered. No combinational path runs from inputs to outputs.
- Asynchronous reset mid-burst returns everything to reset values at once.

## Structure
- Shared package epmp_pkg holds the state enum (IDLE, BURST, DONE) and DIR_UP/DIR_DOWN constants.
- Sub-module epmp_addr_step: combinational; inputs a, dir, page_wrap; outputs next address and wrap flag. It is shared by the inc/dec and burst paths.

## Test plan
- Reset then ld with be = 2'b11, ib = 16'h1234 -> a = 16'h1234 next cycle. Then be = 2'b01, ib = 16'hFFAB -> a = 16'h12AB.
- a = 16'h12FF, page_wrap = 1, inc -> a = 16'h1200 and carry pulses. Same with page_wrap = 0 -> a = 16'h1300 and no carry.
- a = 16'h0100, burst_len = 4, dir up, a_ready = 1 -> a_valid for 4 cycles showing 0100..0103, done next cycle, final a = 16'h0104.
- Same burst with a_ready toggling 1,0,1,0 -> 4 addresses accepted, a holds while ready is low, done after the 4th handshake only.
- burst_len = 0 -> done one cycle after start, a_valid never high, a unchanged. burst_abort after 2 accepts -> busy low next cycle, no done, a = start+2.
- a = 16'h0000, page_wrap = 0, burst_len = 2, dir down -> addresses 0000 then FFFF, carry pulses once, final a = 16'hFFFE.
